pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the hold/bubble controls of the PC and the IF/ID and ID/EX stage registers.
- Detects load-use hazards and resolves taken branches.
- Sequences the multi-cycle HI/LO multiply/divide unit with a busy FSM and a cycle counter.
- Sits beside the stage-register chain (IF/ID, ID/EX, EX/MEM, MEM/WB); it observes ID and EX fields and emits per-stage enables.

Parameters:
- MULT_CYCLES, 4, latency of mult/multu in clk cycles (legal range 2..255).
- DIV_CYCLES, 32, latency of div/divu in clk cycles (legal range 2..255).
- CNT_W, 8, width of the internal mul/div cycle counter.

Ports:
- clk  in  1  pipeline clock; state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- idRs  in  5  rs field of the instruction in ID.
- idRt  in  5  rt field of the instruction in ID.
- idUsesRs  in  1  ID instruction reads rs.
- idUsesRt  in  1  ID instruction reads rt.
- idIsMulDiv  in  1  ID instruction is mult/multu/div/divu.
- idIsDiv  in  1  qualifies idIsMulDiv: 1 = div/divu.
- idUsesHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- exMemRead  in  1  EX instruction is a load.
- exWriteReg  in  5  destination register of the EX instruction.
- exBranchTaken  in  1  branch/jump resolved taken in EX.
- stallPC  out  1  hold PC.
- stallIF  out  1  hold IF/ID register.
- flushIF  out  1  load NOP into IF/ID.
- flushID  out  1  load NOP (bubble) into ID/EX.
- mdStart  out  1  one-cycle start pulse to the mul/div unit.
- mdIsDiv  out  1  operation select, valid with mdStart.
- mdBusy  out  1  mul/div operation in flight.
- mdDone  out  1  final busy cycle; HI/LO are written at the following edge.

Behaviour:
- FSM states: RUN, MD_BUSY. Counter cnt is CNT_W bits wide.
- Reset (async, rst=1):
  - state = RUN, cnt = 0.
  - All outputs are forced 0 while rst is high, regardless of inputs.
- Load-use hazard (luHaz), combinational:
  - luHaz = exMemRead & (exWriteReg != 0) & ((idUsesRs & idRs == exWriteReg) | (idUsesRt & idRt == exWriteReg)).
- Mul/div hazard (mdHaz), combinational:
  - mdHaz = (state == MD_BUSY) & (idIsMulDiv | idUsesHiLo).
- Output priority, highest first:
  1. exBranchTaken: flushIF=1, flushID=1, stallPC=0, stallIF=0, mdStart=0. The ID instruction is wrong-path; an in-flight mul/div continues unaffected.
  2. luHaz | mdHaz: stallPC=1, stallIF=1, flushID=1, flushIF=0, mdStart=0.
  3. Otherwise: all stall/flush outputs are 0.
- Issue:
  - mdStart=1 when state==RUN, idIsMulDiv, no branch and no luHaz.
  - mdIsDiv = idIsDiv whenever mdStart=1, else 0.
  - At the same rising edge: state <= MD_BUSY; cnt <= (idIsDiv ? DIV_CYCLES : MULT_CYCLES) - 1.
- MD_BUSY:
  - mdBusy=1; cnt decrements by 1 each edge.
  - mdDone = (cnt == 0). At that edge state <= RUN.
  - A HI/LO consumer in ID during the mdDone cycle is still stalled. It proceeds, or issues if it is a mul/div, in the next cycle.
  - The busy period is exactly N cycles from the edge that captured mdStart, for N = MULT_CYCLES or DIV_CYCLES.
- Independent instructions (no HI/LO use) flow freely during MD_BUSY.
- Simultaneous luHaz and mdHaz produce a single stall; the outputs are identical to either hazard alone.
- The counter never wraps: decrement happens only in MD_BUSY with cnt > 0.
- Reset asserted mid-operation aborts the mul/div and returns to RUN immediately (asynchronously).

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, add three outputs:
  - stallCycles (32 bit): cycles with stallPC=1.
  - flushCycles (32 bit): cycles with exBranchTaken=1.
  - mdOps (32 bit): mdStart pulses.
- The counters reset to 0, increment on the rising edge, and saturate at 0xFFFFFFFF.
- When the macro is undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Load-use: exMemRead=1, exWriteReg=8, idRs=8, idUsesRs=1 -> stallPC=stallIF=flushID=1 for exactly 1 cycle. The same case with exWriteReg=0 -> no stall.
- Multiply: idIsMulDiv=1, idIsDiv=0 in RUN -> mdStart=1 for 1 cycle, then mdBusy=1 for 4 cycles, with mdDone in the 4th. An mfhi held in ID is stalled 4 cycles and released in the 5th.
- Divide back-to-back: div followed by mult in ID -> mult is stalled 32 cycles, then mdStart (mdIsDiv=0) in cycle 33.
- Branch priority: exBranchTaken=1 with a load-use hazard and idIsMulDiv=1 present -> flushIF=flushID=1, stallPC=0, mdStart=0. The state stays RUN.
- Independent ALU instruction during MD_BUSY -> no stall, and cnt still counts down to 0 on schedule.
- Reset mid-divide: assert rst at busy cycle 10 of 32 -> mdBusy=0 immediately. After release, a new mult issues normally with 4-cycle busy.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline with mul/div sequencing.
// Optional perf counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRs,
  input  logic       idUsesRt,
  input  logic       idIsMulDiv,
  input  logic       idIsDiv,
  input  logic       idUsesHiLo,
  input  logic       exMemRead,
  input  logic [4:0] exWriteReg,
  input  logic       exBranchTaken,
  output logic       stallPC,
  output logic       stallIF,
  output logic       flushIF,
  output logic       flushID,
  output logic       mdStart,
  output logic       mdIsDiv,
  output logic       mdBusy,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0] stallCycles,
  output logic [31:0] flushCycles,
  output logic [31:0] mdOps,
`endif
  output logic       mdDone
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic lu_haz;
  logic md_haz;
  logic busy;
  logic cnt_zero;
  logic start_w;

  assign busy     = (state_q == MD_BUSY);
  assign cnt_zero = (cnt_q == '0);

  // hazard detection and issue qualification
  always_comb begin
    lu_haz = exMemRead && (exWriteReg != 5'd0) &&
             ((idUsesRs && (idRs == exWriteReg)) ||
              (idUsesRt && (idRt == exWriteReg)));
    md_haz  = busy && (idIsMulDiv || idUsesHiLo);
    start_w = !busy && idIsMulDiv && !exBranchTaken && !lu_haz;
  end

  // prioritised stall/flush outputs, all forced low during reset
  always_comb begin
    stallPC = 1'b0;
    stallIF = 1'b0;
    flushIF = 1'b0;
    flushID = 1'b0;
    mdStart = 1'b0;
    mdIsDiv = 1'b0;
    mdBusy  = 1'b0;
    mdDone  = 1'b0;
    if (!rst) begin
      if (exBranchTaken) begin
        flushIF = 1'b1;
        flushID = 1'b1;
      end else if (lu_haz || md_haz) begin
        stallPC = 1'b1;
        stallIF = 1'b1;
        flushID = 1'b1;
      end
      mdStart = start_w;
      mdIsDiv = start_w && idIsDiv;
      mdBusy  = busy;
      mdDone  = busy && cnt_zero;
    end
  end

  // mul/div busy FSM next state and countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (start_w) begin
          state_d = MD_BUSY;
          cnt_d   = idIsDiv ? DIV_LD : MUL_LD;
        end
      end
      MD_BUSY: begin
        if (cnt_zero) state_d = RUN;
        else          cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q, ops_q;

  // saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      ops_q   <= '0;
    end else begin
      if (stallPC && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
      if (exBranchTaken && (flush_q != 32'hFFFF_FFFF))
        flush_q <= flush_q + 32'd1;
      if (mdStart && (ops_q != 32'hFFFF_FFFF))
        ops_q <= ops_q + 32'd1;
    end
  end

  assign stallCycles = stall_q;
  assign flushCycles = flush_q;
  assign mdOps       = ops_q;
`endif

endmodule
